// File: rtl/pipeline_credit_sink.sv
// Credit-managed elastic buffer behind a fixed-latency, non-stalling delay line.
// Owns the producer's credits, flushes stale pipeline contents after reset, drains over valid/ready.
module pipeline_credit_sink #(
    parameter int Width   = 15,
    parameter int Depth   = 2,
    parameter int Entries = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           issue_i,
    output logic                           credit_avail_o,
    input  logic                           in_valid_i,
    input  logic [Width-1:0]               in_data_i,
    output logic                           out_valid_o,
    output logic [Width-1:0]               out_data_o,
    input  logic                           out_ready_i,
    output logic [$clog2(Entries+1)-1:0]   count_o,
    output logic                           credit_err_o,
    output logic                           overflow_err_o
);

    localparam int CntW = $clog2(Entries + 1);
    localparam int PtrW = (Entries > 1) ? $clog2(Entries) : 1;
    localparam int FlW  = (Depth > 0) ? $clog2(Depth + 1) : 1;

    logic [CntW-1:0]  credits_q, credits_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FlW-1:0]   flush_q, flush_d;
    logic             credit_err_q, credit_err_d;
    logic             overflow_err_q, overflow_err_d;
    logic [Width-1:0] mem_q [Entries];

    logic flushing, pop, take, wr_req, wr_en;

    // Pointers wrap explicitly so Entries need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Entries - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign flushing       = (flush_q != '0);
    assign credit_avail_o = !flushing && (credits_q != '0);
    assign out_valid_o    = (count_q != '0);
    assign out_data_o     = mem_q[rd_ptr_q];
    assign count_o        = count_q;
    assign credit_err_o   = credit_err_q;
    assign overflow_err_o = overflow_err_q;

    assign pop    = out_valid_o && out_ready_i;
    assign take   = issue_i && credit_avail_o;
    assign wr_req = in_valid_i && !flushing;
    assign wr_en  = wr_req && ((count_q != CntW'(Entries)) || pop);

    always_comb begin
        credits_d      = credits_q;
        count_d        = count_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        flush_d        = flushing ? flush_q - FlW'(1) : flush_q;
        credit_err_d   = credit_err_q   || (issue_i && !credit_avail_o);
        overflow_err_d = overflow_err_q || (wr_req && !wr_en);

        if (take && !pop)
            credits_d = credits_q - CntW'(1);
        else if (pop && !take && credits_q != CntW'(Entries))
            credits_d = credits_q + CntW'(1);

        if (wr_en && !pop)
            count_d = count_q + CntW'(1);
        else if (pop && !wr_en)
            count_d = count_q - CntW'(1);

        if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)   rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_q      <= CntW'(Entries);
            count_q        <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            flush_q        <= FlW'(Depth);
            credit_err_q   <= 1'b0;
            overflow_err_q <= 1'b0;
        end else begin
            credits_q      <= credits_d;
            count_q        <= count_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            flush_q        <= flush_d;
            credit_err_q   <= credit_err_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    // Storage is not reset; out_data is only meaningful while out_valid is high.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= in_data_i;
    end

endmodule

// File: tb/tb_pipeline_credit_sink.sv
// Randomized scoreboard bench: an un-reset delay line feeds the sink; a negedge monitor
// checks head data, occupancy and credit availability against outstanding-item bookkeeping.
module tb_pipeline_credit_sink;

    localparam int W = 15;
    localparam int D = 2;
    localparam int E = 8;

    logic clk = 1'b0, rst_n = 1'b0;
    logic issue_i = 1'b0, lg_i = 1'b0, out_ready_i = 1'b0, force_v = 1'b0;
    logic [W-1:0] issue_d = '0, force_d = '0;
    logic in_valid_i;
    logic [W-1:0] in_data_i, out_data_o;
    logic credit_avail_o, out_valid_o, credit_err_o, overflow_err_o;
    logic [$clog2(E+1)-1:0] count_o;

    logic [D-1:0]        pv = '0, pl = '0;
    logic [D-1:0][W-1:0] pd = '0;
    int  since = 0;
    int  nchk = 0, nfail = 0, pops = 0;
    bit  model_en = 1'b0;
    logic [W-1:0] exp_q[$];

    pipeline_credit_sink #(.Width(W), .Depth(D), .Entries(E)) dut (
        .clk(clk), .rst_n(rst_n), .issue_i(issue_i), .credit_avail_o(credit_avail_o),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .out_valid_o(out_valid_o),
        .out_data_o(out_data_o), .out_ready_i(out_ready_i), .count_o(count_o),
        .credit_err_o(credit_err_o), .overflow_err_o(overflow_err_o)
    );

    always #5 clk = ~clk;

    // Upstream delay line: never reset, so stale items survive a reset.
    assign in_valid_i = force_v | pv[D-1];
    assign in_data_i  = force_v ? force_d : pd[D-1];

    always @(posedge clk) begin
        pv <= {pv[D-2:0], issue_i};
        pd <= {pd[D-2:0], issue_d};
    end

    // Marks which in-flight items were legally launched since the last reset.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) pl <= '0; else pl <= {pl[D-2:0], lg_i};

    always @(posedge clk or negedge rst_n)
        if (!rst_n) since <= 0; else since <= since + 1;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endfunction

    // Monitor: occupancy = legally issued items not yet popped minus those still in flight.
    always @(negedge clk) begin
        int pend, outst, infl;
        if (rst_n) begin
            pend  = (issue_i && lg_i) ? 1 : 0;
            outst = exp_q.size() - pend;
            infl  = $countones(pv & pl);
            if (model_en) begin
                chk("count", count_o, outst - infl);
                chk("out_valid", out_valid_o, (outst - infl) != 0);
                chk("credit_avail", credit_avail_o, (since >= D) && (outst < E));
            end
            if (out_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    chk("head_data", out_data_o, exp_q[0]);
                    if (out_ready_i) begin
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Producer: launches only when it holds a credit.
    task automatic step(input bit want);
        if (want && credit_avail_o === 1'b1) begin
            issue_i = 1'b1;
            lg_i    = 1'b1;
            issue_d = W'($urandom);
            exp_q.push_back(issue_d);
        end else begin
            issue_i = 1'b0;
            lg_i    = 1'b0;
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            out_ready_i = 1'b1;
            step(1'b0);
        end
        chk("drained", exp_q.size(), 0);
    endtask

    task automatic fill(output int nacc);
        nacc = 0;
        for (int i = 0; i < 14; i++) begin
            cyc();
            out_ready_i = 1'b0;
            step(1'b1);
            if (issue_i) nacc++;
        end
        cyc();
        step(1'b0);
    endtask

    initial begin
        int nacc, p0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_credit_avail", credit_avail_o, 0);
        chk("rst_credit_err", credit_err_o, 0);
        chk("rst_overflow_err", overflow_err_o, 0);

        // Flush: stale valid data presented for the first Depth cycles must be dropped
        @(posedge clk);
        #3;
        rst_n = 1'b1; force_v = 1'b1; force_d = 15'h1234; model_en = 1'b1;
        @(negedge clk); chk("flush_cav0", credit_avail_o, 0);
        @(negedge clk); chk("flush_cav1", credit_avail_o, 0);
        cyc();
        force_v = 1'b0;
        @(negedge clk);
        chk("flush_cav2", credit_avail_o, 1);
        chk("flush_count", count_o, 0);

        // Streaming at full throughput
        p0 = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            out_ready_i = 1'b1;
            step(1'b1);
            if (i == 10) p0 = pops;
            if (i == 60) chk("stream_rate", pops - p0, 50);
        end
        chk("stream_credit_err", credit_err_o, 0);
        chk("stream_overflow_err", overflow_err_o, 0);

        // Random issue and backpressure
        for (int i = 0; i < 300; i++) begin
            cyc();
            out_ready_i = ($urandom_range(0, 2) != 0);
            step($urandom_range(0, 3) != 0);
        end
        drain(12);
        chk("rand_credit_err", credit_err_o, 0);
        chk("rand_overflow_err", overflow_err_o, 0);

        // Backpressure: exactly Entries launches, then illegal issue and overflow
        fill(nacc);
        chk("bp_accepted", nacc, E);
        @(negedge clk);
        chk("bp_count", count_o, E);
        chk("bp_cav", credit_avail_o, 0);
        issue_i = 1'b1; lg_i = 1'b0; issue_d = 15'h7abc;
        cyc();
        issue_i = 1'b0;
        @(negedge clk);
        chk("credit_err_set", credit_err_o, 1);
        chk("credit_err_cav", credit_avail_o, 0);
        chk("no_overflow_yet", overflow_err_o, 0);
        repeat (D + 1) cyc();
        @(negedge clk);
        chk("overflow_err_set", overflow_err_o, 1);
        chk("overflow_count", count_o, E);
        drain(12);
        chk("bp_cav_back", credit_avail_o, 1);
        fill(nacc);
        chk("bp_refill_accepted", nacc, E);
        drain(12);

        // Reset mid-stream with four buffered and two in flight
        for (int i = 0; i < 6; i++) begin
            cyc();
            out_ready_i = 1'b0;
            step(1'b1);
        end
        cyc();
        step(1'b0);
        @(negedge clk);
        chk("mid_count", count_o, 4);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_out_valid", out_valid_o, 0);
        chk("mid_rst_count", count_o, 0);
        chk("mid_rst_credit_err", credit_err_o, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            out_ready_i = 1'b1;
            step(1'b1);
        end
        drain(12);
        chk("mid_overflow_err", overflow_err_o, 0);

        // Simultaneous write and pop while full, across pointer wraps
        fill(nacc);
        model_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("wrpop_count", count_o, E);
            out_ready_i = 1'b1;
            force_v = 1'b1;
            force_d = W'($urandom);
            exp_q.push_back(force_d);
        end
        cyc();
        force_v = 1'b0;
        chk("wrpop_count_end", count_o, E);
        drain(12);
        chk("wrpop_empty", count_o, 0);
        chk("wrpop_overflow_err", overflow_err_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/pipeline_credit_sink.md
Name: pipeline_credit_sink

Overview:
- Elastic output buffer directly downstream of the fixed-latency, non-stalling `pipeline` delay line.
- The pipeline cannot be back-pressured, so this block owns a credit counter. It tells the upstream producer when it may launch an item.
- Items land here Depth cycles after launch and are stored in an Entries-deep circular buffer.
- The buffer drains to a consumer over a valid/ready handshake.

Parameters:
- Width, 15: data width carried through the pipeline.
- Depth, 2: latency of the upstream pipeline, in cycles. Also the post-reset flush length. Legal range 0..63.
- Entries, 8: buffer capacity and initial credit count. Must be >= 1. Full throughput requires Entries >= Depth+2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- issue  in  1  producer launched an item into the pipeline this cycle.
- credit_avail  out  1  producer may launch this cycle.
- in_valid  in  1  valid bit delayed alongside the data by the pipeline.
- in_data  in  Width  pipeline q output.
- out_valid  out  1  head of buffer is valid.
- out_data  out  Width  head-of-buffer data.
- out_ready  in  1  consumer accepts the head item.
- count  out  $clog2(Entries+1)  current buffer occupancy.
- credit_err  out  1  sticky: issue seen while credit_avail=0.
- overflow_err  out  1  sticky: write attempted while full with no pop.

Behaviour:
- Reset (rst_n=0, asynchronous), all cleared immediately:
  - credits=Entries; count=0; rd_ptr=wr_ptr=0.
  - out_valid=0; credit_err=0; overflow_err=0.
  - flush_cnt=Depth.
  - out_data is don't-care while out_valid=0.
- Flush, all synchronous:
  - flush_cnt decrements by 1 per clk after rst_n deasserts, saturating at 0.
  - While flush_cnt != 0: in_valid is ignored and credit_avail=0. This discards stale data still inside the un-reset pipeline.
  - With Depth=0 the flush phase is skipped.
- credit_avail = (flush_cnt==0) && (credits != 0). It is combinational from registers only and never depends on issue.
- Credits:
  - issue && credit_avail decrements credits.
  - A pop (out_valid && out_ready) increments credits.
  - Both in the same cycle: credits unchanged.
  - issue while credit_avail=0: credits unchanged and credit_err is set (sticky until reset).
  - credits never exceed Entries and never go below 0.
- Write:
  - Condition: in_valid && flush_cnt==0.
  - Accepted if count<Entries, or if a pop occurs in the same cycle.
  - When accepted: mem[wr_ptr]<=in_data, and wr_ptr increments, wrapping Entries-1 -> 0 (Entries need not be a power of 2).
  - When not accepted: data is dropped and overflow_err is set (sticky).
- Read:
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr], a read of registered storage with no bypass.
  - A pop increments rd_ptr with the same wrap rule.
- Count update:
  - write only: +1.
  - pop only: -1.
  - both, or neither: unchanged.
- Latency:
  - in_valid at edge N makes out_valid=1 (when previously empty) after edge N+1. Minimum input-to-output latency is 1 cycle.
  - Credit round trip: launch at cycle t, arrival t+Depth, visible t+Depth+1, pop at t+Depth+1, credit usable at t+Depth+2.
- Order: strict FIFO. out_data must equal in_data values in arrival order.
- Handshake: out_data must hold stable while out_valid=1 && out_ready=0.
- Reset mid-operation: buffered items and in-flight credits are lost. The flush then discards up to Depth stale pipeline outputs.
- Invariant with a compliant producer: credits + count + items in flight == Entries, so overflow_err never fires.

Test Plan:
- Reset + flush, Depth=2: hold in_valid=1 with in_data=0x1234 for the first 2 cycles after rst_n rises -> count stays 0, credit_avail=0 for exactly 2 cycles, then goes to 1.
- Streaming, Entries=8, Depth=2, out_ready=1, producer issues whenever credit_avail=1 for 100 cycles with random data -> outputs match inputs in order, one item per cycle after a 3-cycle fill, and both error flags stay 0.
- Backpressure, out_ready=0 -> exactly 8 issues accepted, credit_avail=0 afterwards, count=8, out_data stable. Then raise out_ready -> 8 pops in order, credits return to 8.
- Illegal issue: force issue=1 while credits=0 -> credit_err=1 and credits still 0. Force in_valid while count=8 with out_ready=0 -> overflow_err=1, count stays 8, stored data unchanged.
- Simultaneous write+pop at full, and at each pointer wrap (Entries=5, 20 items) -> count holds at 5 and no item is lost or duplicated.
- Reset mid-stream with count=4: pulse rst_n low for 1 cycle, asynchronously between edges -> out_valid=0 immediately, credits=Entries. Then 2 stale pipeline outputs are discarded and fresh data flows correctly.
